// File: rtl/apu_reg_writer.sv
// apu_reg_writer: parses two-byte write frames into the pulse-channel registers and raises the side-effect requests each write needs
module apu_reg_writer #(
    parameter logic [5:0] HDR_TAG = 6'b101000,
    parameter int         TIMEOUT = 1024
) (
    input  logic       apu_clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       qtr_tick,
    input  logic       hlf_tick,
    output logic [7:0] reg_0,
    output logic [7:0] reg_1,
    output logic [7:0] reg_2,
    output logic [7:0] reg_3,
    output logic       length_reload,
    output logic       env_restart,
    output logic       sweep_reload,
    output logic       seq_reset,
    output logic [7:0] frame_err
);
    typedef enum logic {IDLE, WAIT_DATA} state_t;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    state_t      state, state_nx;
    logic [1:0]  idx, idx_nx;
    logic [15:0] cnt, cnt_nx;
    logic [7:0]  regs [4];
    logic        wr, err, wr3;
    // frame parser: header latches the index, next byte is data, silence past the timeout is an error
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        wr       = 1'b0;
        err      = 1'b0;
        if (state == IDLE) begin
            if (rx_valid && rx_data[7:2] == HDR_TAG) begin
                idx_nx   = rx_data[1:0];
                cnt_nx   = '0;
                state_nx = WAIT_DATA;
            end else begin
                err = rx_valid;
            end
        end else if (rx_valid) begin
            wr       = 1'b1;
            state_nx = IDLE;
        end else if (cnt == TO_LAST) begin
            err      = 1'b1;
            state_nx = IDLE;
        end else begin
            cnt_nx = cnt + 16'd1;
        end
    end
    // parser state register
    always_ff @(posedge apu_clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
        end
    end
    assign wr3 = wr && idx == 2'd3;
    // register file, request flags (set beats clear) and saturating error count
    always_ff @(posedge apu_clk) begin
        if (rst) begin
            regs          <= '{default: '0};
            length_reload <= 1'b0;
            env_restart   <= 1'b0;
            sweep_reload  <= 1'b0;
            seq_reset     <= 1'b0;
            frame_err     <= '0;
        end else begin
            if (wr) regs[idx] <= rx_data;
            seq_reset     <= wr3;
            length_reload <= wr3 || (length_reload && !hlf_tick);
            env_restart   <= wr3 || (env_restart && !qtr_tick);
            sweep_reload  <= (wr && idx == 2'd1) || (sweep_reload && !hlf_tick);
            frame_err     <= frame_err + 8'(err && frame_err != 8'hFF);
        end
    end
    assign reg_0 = regs[0];
    assign reg_1 = regs[1];
    assign reg_2 = regs[2];
    assign reg_3 = regs[3];
endmodule

// File: tb/tb_apu_reg_writer.sv
// tb_apu_reg_writer: random and directed frames checked every cycle against a frame-level model
module tb_apu_reg_writer;
    localparam int TO = 20;
    logic       apu_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0, qtr_tick = 1'b0, hlf_tick = 1'b0;
    logic [7:0] reg_0, reg_1, reg_2, reg_3, frame_err;
    logic       length_reload, env_restart, sweep_reload, seq_reset;
    int         n_chk = 0, n_fail = 0;
    bit         started = 1'b0;
    logic [7:0] m_reg [4];
    bit         m_lr, m_er, m_sw, m_seq, pend, s1, s3;
    int         m_err, gap;
    logic [1:0] pidx;

    apu_reg_writer #(.TIMEOUT(TO)) dut (
        .apu_clk(apu_clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .qtr_tick(qtr_tick), .hlf_tick(hlf_tick), .reg_0(reg_0), .reg_1(reg_1),
        .reg_2(reg_2), .reg_3(reg_3), .length_reload(length_reload),
        .env_restart(env_restart), .sweep_reload(sweep_reload),
        .seq_reset(seq_reset), .frame_err(frame_err)
    );

    always #5 apu_clk = ~apu_clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // model: a frame is pending after a header; data or TO silent cycles end it
    always @(posedge apu_clk) begin
        if (rst) begin
            m_reg = '{default: '0};
            {m_lr, m_er, m_sw, m_seq, pend} = '0;
            m_err = 0;
            gap = 0;
        end else begin
            s1 = 0;
            s3 = 0;
            if (pend && rx_valid) begin
                m_reg[pidx] = rx_data;
                s3 = pidx == 3;
                s1 = pidx == 1;
                pend = 0;
            end else if (pend) begin
                gap++;
                if (gap == TO) begin
                    pend = 0;
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                end
            end else if (rx_valid) begin
                if (rx_data[7:2] == 6'b101000) begin
                    pend = 1;
                    pidx = rx_data[1:0];
                    gap = 0;
                end else begin
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                end
            end
            m_seq = s3;
            m_lr = s3 || (m_lr && !hlf_tick);
            m_er = s3 || (m_er && !qtr_tick);
            m_sw = s1 || (m_sw && !hlf_tick);
        end
    end

    // every-cycle comparison against the model
    always @(negedge apu_clk) begin
        if (started) begin
            check("reg_0", reg_0, m_reg[0]);
            check("reg_1", reg_1, m_reg[1]);
            check("reg_2", reg_2, m_reg[2]);
            check("reg_3", reg_3, m_reg[3]);
            check("length_reload", 8'(length_reload), 8'(m_lr));
            check("env_restart", 8'(env_restart), 8'(m_er));
            check("sweep_reload", 8'(sweep_reload), 8'(m_sw));
            check("seq_reset", 8'(seq_reset), 8'(m_seq));
            check("frame_err", frame_err, 8'(m_err));
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic q, input logic h);
        rx_valid = v;
        rx_data  = d;
        qtr_tick = q;
        hlf_tick = h;
        @(negedge apu_clk);
        rx_valid = 1'b0;
        qtr_tick = 1'b0;
        hlf_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge apu_clk);
        started = 1'b1;
        check("rst_reg_3", reg_3, 8'h00);
        check("rst_frame_err", frame_err, 8'h00);
        check("rst_flags", 8'({length_reload, env_restart, sweep_reload, seq_reset}), 8'h0);
        rst = 1'b0;
        cyc(1, 8'hA3, 0, 0);
        cyc(1, 8'h5C, 0, 0);
        check("w3_reg_3", reg_3, 8'h5C);
        check("w3_seq", 8'(seq_reset), 8'h1);
        check("w3_len_env", 8'({length_reload, env_restart}), 8'h3);
        check("w3_reg_0", reg_0, 8'h00);
        cyc(0, 0, 0, 0);
        check("w3_seq_one", 8'(seq_reset), 8'h0);
        cyc(0, 0, 1, 1);
        check("ticks_clear", 8'({length_reload, env_restart}), 8'h0);
        cyc(1, 8'hA1, 0, 0);
        cyc(1, 8'h8F, 0, 0);
        check("w1_reg_1", reg_1, 8'h8F);
        repeat (9) cyc(0, 0, 0, 0);
        check("sweep_held", 8'(sweep_reload), 8'h1);
        check("env_untouched", 8'(env_restart), 8'h0);
        cyc(0, 0, 0, 1);
        check("sweep_clear", 8'(sweep_reload), 8'h0);
        cyc(1, 8'hA3, 0, 0);
        cyc(1, 8'h11, 1, 0);
        check("set_wins", 8'(env_restart), 8'h1);
        cyc(0, 0, 1, 0);
        check("env_next_tick", 8'(env_restart), 8'h0);
        do_reset();
        cyc(1, 8'hA2, 0, 0);
        repeat (TO - 1) cyc(0, 0, 0, 0);
        check("before_timeout", frame_err, 8'h00);
        cyc(0, 0, 0, 0);
        check("timeout_err", frame_err, 8'h01);
        cyc(1, 8'h77, 0, 0);
        check("late_byte_err", frame_err, 8'h02);
        check("reg_2_kept", reg_2, 8'h00);
        do_reset();
        cyc(1, 8'hA0, 0, 0);
        cyc(1, 8'hA1, 0, 0);
        check("hdr_as_data", reg_0, 8'hA1);
        cyc(1, 8'h42, 0, 0);
        check("non_hdr_err", frame_err, 8'h01);
        for (int i = 0; i < 300; i++) cyc(1, 8'h42, 0, 0);
        check("err_saturate", frame_err, 8'hFF);
        cyc(1, 8'hA3, 0, 0);
        rst = 1'b1;
        cyc(1, 8'h5C, 0, 0);
        rst = 1'b0;
        check("mid_rst_reg_3", reg_3, 8'h00);
        check("mid_rst_err", frame_err, 8'h00);
        cyc(0, 0, 0, 0);
        check("mid_rst_seq", 8'(seq_reset), 8'h0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0)
                repeat (TO + $urandom_range(0, 3)) cyc(0, 0, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
            rst = ($urandom_range(0, 299) == 0);
            cyc(1'($urandom_range(0, 2) == 0),
                $urandom_range(0, 1) ? {6'b101000, 2'($urandom_range(0, 3))} : 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
            rst = 1'b0;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/apu_reg_writer.md
Name: apu_reg_writer

Overview:
- Front end that writes the 4-byte pulse-channel register set (reg_0..reg_3) from a received byte stream, e.g. the UART receiver output.
- Parses two-byte write frames and holds the register bytes.
- Generates the side-effect requests the pulse channel needs: length reload, envelope restart, sweep reload and sequencer reset. These replace whole-register change detection with explicit write events.
- Sits between the serial byte receiver and the pulse channel in the apu_clk domain.

Parameters:
- HDR_TAG, 6'b101000: required value of header bits [7:2].
- TIMEOUT, 1024: apu_clk cycles allowed between header and data byte; legal range 2..65535.

Ports:
- apu_clk  input  1  sole clock
- rst  input  1  synchronous, active-high reset
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
- qtr_tick  input  1  one-cycle quarter-frame enable, apu_clk domain
- hlf_tick  input  1  one-cycle half-frame enable, apu_clk domain
- reg_0  output  8  duty/halt/envelope register
- reg_1  output  8  sweep register
- reg_2  output  8  timer low register
- reg_3  output  8  length select / timer high register
- length_reload  output  1  pending length-counter reload request
- env_restart  output  1  pending envelope restart request
- sweep_reload  output  1  pending sweep reload request
- seq_reset  output  1  one-cycle sequencer reset pulse
- frame_err  output  8  saturating count of protocol errors

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, timeout counter is 0. Reset overrides every other input in the same cycle.
- Frame format: header byte, then data byte.
  - Header is valid when rx_data[7:2] == HDR_TAG; rx_data[1:0] selects the register index.
- FSM states: IDLE and WAIT_DATA.
- IDLE:
  - rx_valid with a valid header: latch the index, clear the timeout counter, go to WAIT_DATA.
  - rx_valid with a non-header byte: frame_err += 1, stay in IDLE.
- WAIT_DATA:
  - rx_valid: any byte value, including one matching a header, is taken as data. Write reg_<idx> on the next edge, go to IDLE.
  - No rx_valid: increment the timeout counter. When it reaches TIMEOUT-1 without data: frame_err += 1, return to IDLE, no write.
- frame_err saturates at 8'hFF and never wraps.
- Write latency: reg_n updates on the clock edge after the cycle in which the data byte's rx_valid is high.
- Write side effects, taking effect on the same edge as the register update:
  - idx 3: set length_reload, set env_restart, assert seq_reset high for exactly one cycle.
  - idx 1: set sweep_reload.
  - idx 0 and idx 2: register update only.
- Request flag clearing:
  - length_reload and sweep_reload clear on the edge after a cycle with hlf_tick high.
  - env_restart clears on the edge after a cycle with qtr_tick high.
- The pulse channel samples the request flags in its tick cycle.
- Same-cycle set and clear: set wins and the flag stays high, so the new write is serviced on the next tick.
- Repeated writes while a flag is pending: the flag stays high; requests do not queue or count.
- Rewriting the same value still raises every side effect.
- Reset asserted mid-frame: the frame is abandoned, no write occurs, frame_err is 0 afterwards.
- seq_reset on back-to-back reg_3 writes: one pulse per write. Writes are at least 2 rx_valid strobes apart, so pulses never merge.

Test Plan:
- Reset, then bytes A3, 5C -> reg_3 = 5C one edge after the second strobe; length_reload = env_restart = 1; seq_reset high for exactly 1 cycle; reg_0..reg_2 remain 00.
- Write reg_1 = 8F (bytes A1, 8F), then hlf_tick pulse 10 cycles later -> sweep_reload high from the write edge until the edge after the tick, then 0. env_restart stays 0 throughout.
- Write reg_3 with qtr_tick coinciding with the data-byte edge -> env_restart still 1 afterwards; it clears only after the next qtr_tick.
- Send header A2, wait TIMEOUT cycles with no data, then send 77 -> reg_2 unchanged; frame_err = 1 from the timeout; 77 in IDLE is not a header, so frame_err = 2.
- Send A0, then A1 as data -> reg_0 = A1, FSM in IDLE; a following 42 is a non-header byte, so frame_err = 1.
- Send 300 non-header bytes -> frame_err holds at FF. Assert rst after header A3 and before data -> all outputs 0, no seq_reset pulse.
